// File: rtl/uart_tx_fifo_if.sv
// Byte-stream and transmitter handshake bundle for uart_tx_fifo.
// slave is the FIFO side; master is the producer / transmitter side.
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PAYLOAD_BITS = 8
);
  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  logic                    in_valid;
  logic [PAYLOAD_BITS-1:0] in_data;
  logic                    ovf_clr;
  logic                    uart_tx_busy;
  logic                    uart_tx_en;
  logic [PAYLOAD_BITS-1:0] uart_tx_data;
  logic [LvlW-1:0]         level;
  logic                    empty;
  logic                    full;
  logic                    overflow;

  modport slave (
    input  in_valid, in_data, ovf_clr, uart_tx_busy,
    output uart_tx_en, uart_tx_data, level, empty, full, overflow
  );

  modport master (
    output in_valid, in_data, ovf_clr, uart_tx_busy,
    input  uart_tx_en, uart_tx_data, level, empty, full, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter with a one-cycle start pulse per byte.
// Define UART_TX_FIFO_CRLF_EN to follow every transmitted 0x0D with an inserted 0x0A.
module uart_tx_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input logic          clk,
  input logic          resetn,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

`ifdef UART_TX_FIFO_CRLF_EN
  typedef enum logic [2:0] {StIdle, StStart, StWaitBusy, StWaitDone, StLf} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StWaitBusy, StWaitDone} state_e;
`endif

  state_e state_q, state_d;

  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]         level_q;
  logic                    ovf_q;
  logic                    en_q;
  logic [PAYLOAD_BITS-1:0] data_q;

  logic                    empty, full, push, pop, load;
  logic [PAYLOAD_BITS-1:0] load_data;

  assign empty = (level_q == '0);
  assign full  = (level_q == LvlW'(DEPTH));
  // A pop frees the slot, so a push while full is still taken on a pop cycle.
  assign push  = bus.in_valid && (!full || pop);

  assign bus.level        = level_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.overflow     = ovf_q;
  assign bus.uart_tx_en   = en_q;
  assign bus.uart_tx_data = data_q;

`ifdef UART_TX_FIFO_CRLF_EN
  logic lf_pend_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lf_pend_q <= 1'b0;
    end else if (pop) begin
      lf_pend_q <= (mem_q[rd_ptr_q] == PAYLOAD_BITS'(8'h0D));
    end else if (state_q == StLf) begin
      lf_pend_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (!empty && !bus.uart_tx_busy) state_d = StStart;
      StStart:    state_d = StWaitBusy;
      StWaitBusy: if (bus.uart_tx_busy) state_d = StWaitDone;
`ifdef UART_TX_FIFO_CRLF_EN
      StWaitDone: if (!bus.uart_tx_busy) state_d = lf_pend_q ? StLf : StIdle;
      StLf:       state_d = StStart;
`else
      StWaitDone: if (!bus.uart_tx_busy) state_d = StIdle;
`endif
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    load      = 1'b0;
    load_data = mem_q[rd_ptr_q];
    unique case (state_q)
      StIdle: begin
        if (!empty && !bus.uart_tx_busy) begin
          pop  = 1'b1;
          load = 1'b1;
        end
      end
`ifdef UART_TX_FIFO_CRLF_EN
      StLf: begin
        load      = 1'b1;
        load_data = PAYLOAD_BITS'(8'h0A);
      end
`endif
      default: ;
    endcase
  end

  // Storage is not reset; only the pointers and level define valid contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
      // A dropped byte wins over a simultaneous clear.
      if (bus.in_valid && !push) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
      en_q <= load;
      if (load) data_q <= load_data;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=16) with a 10-cycle busy model.
module tb_uart_tx_fifo;
  localparam int BusyLen = 10;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt;
  logic busy_hold;
  logic [7:0] tx_q [$];

  uart_tx_fifo_if #(.DEPTH(16), .PAYLOAD_BITS(8)) bus ();

  uart_tx_fifo #(.DEPTH(16), .PAYLOAD_BITS(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises the cycle after the start pulse and lasts BusyLen cycles.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) busy_cnt <= 0;
    else if (bus.uart_tx_en) busy_cnt <= BusyLen;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.uart_tx_busy = busy_hold | (busy_cnt != 0);

  always @(posedge clk) begin
    if (resetn && bus.uart_tx_en) tx_q.push_back(bus.uart_tx_data);
  end

  task automatic push_byte(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int quiet = 0;
    int cyc   = 0;
    while (quiet < 5 && cyc < 1500) begin
      @(negedge clk);
      cyc++;
      if (bus.level == 0 && !bus.uart_tx_busy && !bus.uart_tx_en) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 5) begin
      errors++;
      $display("FAIL %s drain: timed out after %0d cycles, level=%0d required 0", name, cyc,
               bus.level);
    end
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.ovf_clr  = 1'b0;
    busy_hold    = 1'b0;
    resetn       = 1'b0;
    repeat (2) @(negedge clk);
    checks += 6;
    if (bus.level !== 5'd0) begin errors++; $display("FAIL reset level: got %0d required 0", bus.level); end
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset empty: got %b required 1", bus.empty); end
    if (bus.full !== 1'b0) begin errors++; $display("FAIL reset full: got %b required 0", bus.full); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b required 0", bus.overflow); end
    if (bus.uart_tx_en !== 1'b0) begin errors++; $display("FAIL reset en: got %b required 0", bus.uart_tx_en); end
    if (bus.uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset data: got %h required 00", bus.uart_tx_data); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    tx_q.delete();
    push_byte(8'h41);
    checks += 2;
    if (bus.level !== 5'd1) begin errors++; $display("FAIL single level1: got %0d required 1", bus.level); end
    if (bus.uart_tx_en !== 1'b0) begin errors++; $display("FAIL single early en: got %b required 0", bus.uart_tx_en); end
    @(negedge clk);
    checks += 3;
    if (bus.uart_tx_en !== 1'b1) begin errors++; $display("FAIL single en: got %b required 1", bus.uart_tx_en); end
    if (bus.uart_tx_data !== 8'h41) begin errors++; $display("FAIL single data: got %h required 41", bus.uart_tx_data); end
    if (bus.level !== 5'd0) begin errors++; $display("FAIL single level0: got %0d required 0", bus.level); end
    @(negedge clk);
    checks++;
    if (bus.uart_tx_en !== 1'b0) begin errors++; $display("FAIL single en width: got %b required 0", bus.uart_tx_en); end
    drain("single");
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h41) begin
      errors++; $display("FAIL single seq: got %0d bytes required 1 byte 41", tx_q.size());
    end
  endtask

  task automatic test_overflow;
    tx_q.delete();
    busy_hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_byte(8'(i));
      if (i == 15) begin
        checks += 3;
        if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf full16: got %b required 1", bus.full); end
        if (bus.level !== 5'd16) begin errors++; $display("FAIL ovf level16: got %0d required 16", bus.level); end
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf early flag: got %b required 0", bus.overflow); end
      end
    end
    checks += 2;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf flag: got %b required 1", bus.overflow); end
    if (bus.level !== 5'd16) begin errors++; $display("FAIL ovf level: got %0d required 16", bus.level); end
    busy_hold = 1'b0;
    drain("overflow");
    checks++;
    if (tx_q.size() != 16) begin errors++; $display("FAIL ovf count: got %0d required 16", tx_q.size()); end
    for (int i = 0; i < 16 && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== 8'(i)) begin errors++; $display("FAIL ovf order[%0d]: got %h required %h", i, tx_q[i], 8'(i)); end
    end
  endtask

  task automatic test_ovf_clr;
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr flag: got %b required 0", bus.overflow); end
    busy_hold = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'hA0 + 8'(i));
    bus.ovf_clr = 1'b1;
    push_byte(8'hEE);
    bus.ovf_clr = 1'b0;
    checks += 2;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL clr coincident: got %b required 1", bus.overflow); end
    if (bus.level !== 5'd16) begin errors++; $display("FAIL clr level: got %0d required 16", bus.level); end
  endtask

  task automatic test_push_on_pop_full;
    tx_q.delete();
    busy_hold = 1'b0;
    push_byte(8'hBB);
    checks += 3;
    if (bus.level !== 5'd16) begin errors++; $display("FAIL pushpop level: got %0d required 16", bus.level); end
    if (bus.uart_tx_en !== 1'b1) begin errors++; $display("FAIL pushpop en: got %b required 1", bus.uart_tx_en); end
    if (bus.uart_tx_data !== 8'hA0) begin errors++; $display("FAIL pushpop data: got %h required a0", bus.uart_tx_data); end
    drain("pushpop");
    checks++;
    if (tx_q.size() != 17) begin errors++; $display("FAIL pushpop count: got %0d required 17", tx_q.size()); end
    for (int i = 0; i < 17 && i < tx_q.size(); i++) begin
      automatic logic [7:0] exp = (i == 16) ? 8'hBB : 8'hA0 + 8'(i);
      checks++;
      if (tx_q[i] !== exp) begin errors++; $display("FAIL pushpop order[%0d]: got %h required %h", i, tx_q[i], exp); end
    end
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
  endtask

  task automatic test_crlf;
    logic [7:0] exp [$];
`ifdef UART_TX_FIFO_CRLF_EN
    exp = '{8'h0D, 8'h0A, 8'h42};
`else
    exp = '{8'h0D, 8'h42};
`endif
    tx_q.delete();
    push_byte(8'h0D);
    push_byte(8'h42);
    drain("crlf");
    checks++;
    if (tx_q.size() != exp.size()) begin
      errors++; $display("FAIL crlf count: got %0d required %0d", tx_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== exp[i]) begin errors++; $display("FAIL crlf seq[%0d]: got %h required %h", i, tx_q[i], exp[i]); end
    end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 6; i++) push_byte(8'h10 + 8'(i));
    checks++;
    if (bus.level !== 5'd5) begin errors++; $display("FAIL midrst pre level: got %0d required 5", bus.level); end
    #2 resetn = 1'b0;
    #1;
    checks += 3;
    if (bus.level !== 5'd0) begin errors++; $display("FAIL midrst level: got %0d required 0", bus.level); end
    if (bus.uart_tx_en !== 1'b0) begin errors++; $display("FAIL midrst en: got %b required 0", bus.uart_tx_en); end
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL midrst empty: got %b required 1", bus.empty); end
    @(negedge clk);
    resetn = 1'b1;
    tx_q.delete();
    push_byte(8'h55);
    drain("midrst");
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h55) begin
      errors++; $display("FAIL midrst seq: got %0d bytes required 1 byte 55", tx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_ovf_clr();
    test_push_on_pop_full();
    test_crlf();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of byte entries; a power of two, 4..256.
REQ-002 SHALL have parameter PAYLOAD_BITS, default 8, byte width (fixed at 8 when UART_TX_FIFO_CRLF_EN is defined).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic rising-edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, one-cycle push strobe (from uart_rx_valid).
REQ-006 SHALL have port in_data, input, PAYLOAD_BITS, byte sampled when in_valid=1.
REQ-007 SHALL have port ovf_clr, input, 1, clears the overflow flag.
REQ-008 SHALL have port uart_tx_busy, input, 1, busy from the downstream transmitter.
REQ-009 SHALL have port uart_tx_en, output, 1, registered one-cycle start pulse to the transmitter.
REQ-010 SHALL have port uart_tx_data, output, PAYLOAD_BITS, registered byte, stable from the pulse until busy falls.
REQ-011 SHALL have port level, output, log2(DEPTH)+1, current occupancy.
REQ-012 SHALL have ports empty and full, outputs, 1 each, combinational decodes of level.
REQ-013 SHALL have port overflow, output, 1, sticky dropped-byte flag.

Function
REQ-014 SHALL implement a circular FIFO with read/write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 SHALL write in_data and increment level on in_valid when not full.
REQ-016 SHALL drop the byte and set overflow on in_valid when full; level and contents unchanged.
REQ-017 SHALL accept a push in the same cycle as a pop, even when full; level unchanged.
REQ-018 SHALL run FSM states IDLE, START, WAIT_BUSY, WAIT_DONE (and LF when CRLF is enabled).
REQ-019 SHALL move IDLE->START when not empty and uart_tx_busy=0; the pop, the uart_tx_data load and uart_tx_en=1 register on that edge.
REQ-020 SHALL move START->WAIT_BUSY unconditionally; uart_tx_en is high for exactly one cycle.
REQ-021 SHALL move WAIT_BUSY->WAIT_DONE when uart_tx_busy=1, and WAIT_DONE->IDLE when uart_tx_busy=0.
REQ-022 SHALL assert uart_tx_en in the second cycle after the edge that samples in_valid, given an empty FIFO, IDLE, and busy low.
REQ-023 SHALL preserve byte order exactly; no byte is duplicated or lost except per REQ-016.
REQ-024 SHALL give ovf_clr priority below a simultaneous overflow event: the flag stays set.

Reset
REQ-025 SHALL, on resetn low, immediately clear pointers, level=0, empty=1, full=0, overflow=0, uart_tx_en=0, uart_tx_data=0, and FSM=IDLE.
REQ-026 SHALL discard any in-progress byte on mid-operation reset; normal behaviour resumes on the first edge after release.

Configuration
REQ-027 SHALL, with macro UART_TX_FIFO_CRLF_EN defined, go WAIT_DONE->LF after sending popped byte 0x0D; LF sends 0x0A via START/WAIT_BUSY/WAIT_DONE without popping, then returns to IDLE.
REQ-028 SHALL, without UART_TX_FIFO_CRLF_EN, omit the LF state and transmit 0x0D as an ordinary byte.

Verification
REQ-029 SHALL pass: push 0x41 into empty FIFO, busy model (rises 1 cycle after en, 10 cycles long) -> uart_tx_en pulse 2 cycles later with uart_tx_data=0x41, level returns to 0.
REQ-030 SHALL pass: 20 back-to-back pushes 0x00..0x13 with DEPTH=16, busy held high -> full=1 after 16, overflow=1, bytes 0x00..0x0F transmitted in order after busy releases.
REQ-031 SHALL pass: push on the exact cycle of a pop while full -> level stays 16, pushed byte transmitted last.
REQ-032 SHALL pass: with UART_TX_FIFO_CRLF_EN, push 0x0D,0x42 -> transmitted sequence 0x0D,0x0A,0x42; without it -> 0x0D,0x42.
REQ-033 SHALL pass: resetn pulsed low during WAIT_DONE with level=5 -> level=0, uart_tx_en=0 asynchronously; next push 0x55 transmitted normally.
REQ-034 SHALL pass: overflow set, ovf_clr pulsed -> overflow=0 next cycle; ovf_clr coincident with an overflowing push -> overflow stays 1.
